memory_access: RTL and testbench

//  Pipeline stage directly downstream of the execute stage; consumes the ALU result, rs2, funct3, opcode and rd.

---
 rtl/memory_access_pkg.sv | 28 ++
 rtl/mem_lane_align.sv | 85 ++++++++
 rtl/memory_access.sv | 193 +++++++++++++++++++
 tb/tb_memory_access.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory-access pipeline stage: opcode/exception bit
// positions, funct3 load/store encodings and FSM state encodings.
package memory_access_pkg;

    localparam int OPCODE_WIDTH    = 11;
    localparam int LOAD_WORD       = 2;
    localparam int STORE_WORD      = 3;

    localparam int EXCEPTION_WIDTH  = 6;
    localparam int ILLEGAL          = 0;
    localparam int LOAD_MISALIGNED  = 4;
    localparam int STORE_MISALIGNED = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/replicated data, load
// extract with sign/zero extension, and misalignment/illegal-size detection.
module mem_lane_align
    import memory_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        load_illegal,
    output logic        store_illegal
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store strobe and lane-replicated write data
    always_comb begin
        wstrb = 4'b0000;
        wdata = store_data;
        case (funct3)
            F3_SB: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            F3_SH: begin
                wstrb = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            F3_SW: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
            default: begin
                wstrb = 4'b0000;
                wdata = store_data;
            end
        endcase
    end

    // Lane select for the addressed byte
    always_comb begin
        byte_s = load_word[7:0];
        case (addr_lo)
            2'b00:   byte_s = load_word[7:0];
            2'b01:   byte_s = load_word[15:8];
            2'b10:   byte_s = load_word[23:16];
            2'b11:   byte_s = load_word[31:24];
            default: byte_s = load_word[7:0];
        endcase
    end

    assign half_s = addr_lo[1] ? load_word[31:16] : load_word[15:0];

    // Load extract with sign or zero extension
    always_comb begin
        load_data = 32'h0000_0000;
        case (funct3)
            F3_LB:   load_data = {{24{byte_s[7]}}, byte_s};
            F3_LH:   load_data = {{16{half_s[15]}}, half_s};
            F3_LW:   load_data = load_word;
            F3_LBU:  load_data = {24'h00_0000, byte_s};
            F3_LHU:  load_data = {16'h0000, half_s};
            default: load_data = 32'h0000_0000;
        endcase
    end

    // Size in funct3[1:0] determines the alignment requirement
    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase
    end

    assign load_illegal  = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    assign store_illegal = (funct3 >= 3'b011);

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues single-outstanding data-memory requests
// for loads/stores, passes other ops through, and feeds one writeback slot.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int AWIDTH   = 5,
    parameter int DWIDTH   = 32,
    parameter int PC_WIDTH = 32
) (
    input  logic                       m_clk,
    input  logic                       m_rst,
    input  logic                       m_i_valid,
    output logic                       m_o_ready,
    input  logic [OPCODE_WIDTH-1:0]    m_i_opcode,
    input  logic [2:0]                 m_i_funct3,
    input  logic [DWIDTH-1:0]          m_i_result_alu,
    input  logic [DWIDTH-1:0]          m_i_rs2,
    input  logic [AWIDTH-1:0]          m_i_addr_rd,
    input  logic                       m_i_we,
    input  logic [PC_WIDTH-1:0]        m_i_pc,
    input  logic [EXCEPTION_WIDTH-1:0] m_i_exception,
    output logic                       m_o_mem_req,
    output logic                       m_o_mem_we,
    output logic [DWIDTH-1:0]          m_o_mem_addr,
    output logic [DWIDTH-1:0]          m_o_mem_wdata,
    output logic [3:0]                 m_o_mem_wstrb,
    input  logic                       m_i_mem_ack,
    input  logic [DWIDTH-1:0]          m_i_mem_rdata,
    output logic                       m_o_valid,
    output logic [AWIDTH-1:0]          m_o_addr_rd,
    output logic [DWIDTH-1:0]          m_o_data_rd,
    output logic                       m_o_we,
    output logic [PC_WIDTH-1:0]        m_o_pc,
    output logic [EXCEPTION_WIDTH-1:0] m_o_exception
);

    state_e state_r, state_s;

    logic [2:0]                 funct3_r;
    logic [1:0]                 addr_lo_r;
    logic [AWIDTH-1:0]          rd_r;
    logic [PC_WIDTH-1:0]        pc_r;
    logic [EXCEPTION_WIDTH-1:0] exc_r;
    logic                       is_load_r;

    logic                       mem_req_r, mem_we_r, valid_r, we_out_r;
    logic [DWIDTH-1:0]          mem_addr_r, mem_wdata_r, data_rd_r;
    logic [3:0]                 mem_wstrb_r;
    logic [AWIDTH-1:0]          addr_rd_r;
    logic [PC_WIDTH-1:0]        pc_out_r;
    logic [EXCEPTION_WIDTH-1:0] exc_out_r;

    logic                       accept_s, is_load_s, is_store_s, is_mem_s;
    logic                       illegal_s, launch_s, complete_s;
    logic [2:0]                 lane_funct3_s;
    logic [1:0]                 lane_addr_s;
    logic [3:0]                 wstrb_s;
    logic [DWIDTH-1:0]          wdata_s, load_data_s;
    logic                       misaligned_s, load_illegal_s, store_illegal_s;
    logic [EXCEPTION_WIDTH-1:0] fault_exc_s;
    logic                       unused_opcode_s;

    assign unused_opcode_s = ^m_i_opcode;

    assign m_o_ready  = (state_r == ST_IDLE);
    assign accept_s   = m_i_valid & m_o_ready;
    assign is_load_s  = m_i_opcode[LOAD_WORD];
    assign is_store_s = m_i_opcode[STORE_WORD];
    assign is_mem_s   = is_load_s | is_store_s;

    // While a request is outstanding the lane logic extracts the captured access
    assign lane_funct3_s = (state_r == ST_IDLE) ? m_i_funct3 : funct3_r;
    assign lane_addr_s   = (state_r == ST_IDLE) ? m_i_result_alu[1:0] : addr_lo_r;

    mem_lane_align u_lane (
        .funct3        (lane_funct3_s),
        .addr_lo       (lane_addr_s),
        .store_data    (m_i_rs2),
        .load_word     (m_i_mem_rdata),
        .wstrb         (wstrb_s),
        .wdata         (wdata_s),
        .load_data     (load_data_s),
        .misaligned    (misaligned_s),
        .load_illegal  (load_illegal_s),
        .store_illegal (store_illegal_s)
    );

    assign illegal_s  = (is_load_s & load_illegal_s) | (is_store_s & store_illegal_s);
    assign launch_s   = accept_s & is_mem_s & ~illegal_s & ~misaligned_s;
    assign complete_s = (state_r == ST_WAIT_MEM) & mem_req_r & m_i_mem_ack;

    // Fault bit added to the upstream exceptions; illegal size takes priority
    always_comb begin
        fault_exc_s = {EXCEPTION_WIDTH{1'b0}};
        if (is_mem_s & illegal_s) begin
            fault_exc_s[ILLEGAL] = 1'b1;
        end else if (is_load_s & misaligned_s) begin
            fault_exc_s[LOAD_MISALIGNED] = 1'b1;
        end else if (is_store_s & misaligned_s) begin
            fault_exc_s[STORE_MISALIGNED] = 1'b1;
        end else begin
            fault_exc_s = {EXCEPTION_WIDTH{1'b0}};
        end
    end

    // State register
    always_ff @(posedge m_clk) begin
        if (m_rst) state_r <= ST_IDLE;
        else       state_r <= state_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:     state_s = launch_s ? ST_WAIT_MEM : ST_IDLE;
            ST_WAIT_MEM: state_s = complete_s ? ST_IDLE : ST_WAIT_MEM;
            default:     state_s = ST_IDLE;
        endcase
    end

    // Stage capture, memory bus and writeback slot
    always_ff @(posedge m_clk) begin
        if (m_rst) begin
            funct3_r    <= 3'b000;
            addr_lo_r   <= 2'b00;
            rd_r        <= {AWIDTH{1'b0}};
            pc_r        <= {PC_WIDTH{1'b0}};
            exc_r       <= {EXCEPTION_WIDTH{1'b0}};
            is_load_r   <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {DWIDTH{1'b0}};
            mem_wdata_r <= {DWIDTH{1'b0}};
            mem_wstrb_r <= 4'b0000;
            valid_r     <= 1'b0;
            addr_rd_r   <= {AWIDTH{1'b0}};
            data_rd_r   <= {DWIDTH{1'b0}};
            we_out_r    <= 1'b0;
            pc_out_r    <= {PC_WIDTH{1'b0}};
            exc_out_r   <= {EXCEPTION_WIDTH{1'b0}};
        end else begin
            valid_r <= 1'b0;
            if (accept_s) begin
                funct3_r  <= m_i_funct3;
                addr_lo_r <= m_i_result_alu[1:0];
                rd_r      <= m_i_addr_rd;
                pc_r      <= m_i_pc;
                exc_r     <= m_i_exception;
                is_load_r <= is_load_s;
            end
            if (launch_s) begin
                mem_req_r   <= 1'b1;
                mem_we_r    <= is_store_s;
                mem_addr_r  <= {m_i_result_alu[DWIDTH-1:2], 2'b00};
                mem_wdata_r <= wdata_s;
                mem_wstrb_r <= is_store_s ? wstrb_s : 4'b0000;
            end else if (complete_s) begin
                mem_req_r <= 1'b0;
                mem_we_r  <= 1'b0;
            end
            if (complete_s) begin
                valid_r   <= 1'b1;
                addr_rd_r <= rd_r;
                data_rd_r <= is_load_r ? load_data_s : {DWIDTH{1'b0}};
                we_out_r  <= is_load_r & (rd_r != {AWIDTH{1'b0}}) & ~(|exc_r);
                pc_out_r  <= pc_r;
                exc_out_r <= exc_r;
            end else if (accept_s & ~launch_s) begin
                valid_r   <= 1'b1;
                addr_rd_r <= m_i_addr_rd;
                data_rd_r <= m_i_result_alu;
                we_out_r  <= ~is_mem_s & m_i_we & (m_i_addr_rd != {AWIDTH{1'b0}})
                             & ~(|m_i_exception);
                pc_out_r  <= m_i_pc;
                exc_out_r <= m_i_exception | fault_exc_s;
            end
        end
    end

    assign m_o_mem_req   = mem_req_r;
    assign m_o_mem_we    = mem_we_r;
    assign m_o_mem_addr  = mem_addr_r;
    assign m_o_mem_wdata = mem_wdata_r;
    assign m_o_mem_wstrb = mem_wstrb_r;
    assign m_o_valid     = valid_r;
    assign m_o_addr_rd   = addr_rd_r;
    assign m_o_data_rd   = data_rd_r;
    assign m_o_we        = we_out_r;
    assign m_o_pc        = pc_out_r;
    assign m_o_exception = exc_out_r;

endmodule

// File: tb/tb_memory_access.sv
// Directed self-checking bench for memory_access: stores, loads, faults,
// pass-through ops and reset during an outstanding request.
module tb_memory_access;
    import memory_access_pkg::*;

    logic        m_clk = 1'b0;
    logic        m_rst, m_i_valid, m_o_ready;
    logic [10:0] m_i_opcode;
    logic [2:0]  m_i_funct3;
    logic [31:0] m_i_result_alu, m_i_rs2, m_i_pc;
    logic [4:0]  m_i_addr_rd;
    logic        m_i_we;
    logic [5:0]  m_i_exception;
    logic        m_o_mem_req, m_o_mem_we, m_i_mem_ack;
    logic [31:0] m_o_mem_addr, m_o_mem_wdata, m_i_mem_rdata;
    logic [3:0]  m_o_mem_wstrb;
    logic        m_o_valid, m_o_we;
    logic [4:0]  m_o_addr_rd;
    logic [31:0] m_o_data_rd, m_o_pc;
    logic [5:0]  m_o_exception;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [10:0] OP_ALU   = 11'b000_0000_0001;
    localparam logic [10:0] OP_LOAD  = 11'b000_0000_0100;
    localparam logic [10:0] OP_STORE = 11'b000_0000_1000;

    memory_access dut (
        .m_clk(m_clk), .m_rst(m_rst), .m_i_valid(m_i_valid), .m_o_ready(m_o_ready),
        .m_i_opcode(m_i_opcode), .m_i_funct3(m_i_funct3), .m_i_result_alu(m_i_result_alu),
        .m_i_rs2(m_i_rs2), .m_i_addr_rd(m_i_addr_rd), .m_i_we(m_i_we), .m_i_pc(m_i_pc),
        .m_i_exception(m_i_exception), .m_o_mem_req(m_o_mem_req), .m_o_mem_we(m_o_mem_we),
        .m_o_mem_addr(m_o_mem_addr), .m_o_mem_wdata(m_o_mem_wdata),
        .m_o_mem_wstrb(m_o_mem_wstrb), .m_i_mem_ack(m_i_mem_ack),
        .m_i_mem_rdata(m_i_mem_rdata), .m_o_valid(m_o_valid), .m_o_addr_rd(m_o_addr_rd),
        .m_o_data_rd(m_o_data_rd), .m_o_we(m_o_we), .m_o_pc(m_o_pc),
        .m_o_exception(m_o_exception)
    );

    always #5 m_clk = ~m_clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge m_clk);
        @(negedge m_clk);
    endtask

    // Present one instruction for a single accepting edge, then drop valid
    task automatic issue(input logic [10:0] op, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic we,
                         input logic [5:0] exc);
        m_i_valid      = 1'b1;
        m_i_opcode     = op;
        m_i_funct3     = f3;
        m_i_result_alu = alu;
        m_i_rs2        = rs2;
        m_i_addr_rd    = rd;
        m_i_we         = we;
        m_i_exception  = exc;
        m_i_pc         = m_i_pc + 32'd4;
        tick();
        m_i_valid = 1'b0;
    endtask

    // Load answered by zero-wait memory in the first request cycle
    task automatic load_zw(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
        issue(OP_LOAD, f3, addr, 32'h0, 5'd7, 1'b1, 6'h00);
        chk_eq({tag, " req"}, {31'd0, m_o_mem_req}, 32'd1);
        chk_eq({tag, " addr"}, m_o_mem_addr, {addr[31:2], 2'b00});
        m_i_mem_ack   = 1'b1;
        m_i_mem_rdata = rdata;
        tick();
        m_i_mem_ack = 1'b0;
        chk_eq({tag, " valid"}, {31'd0, m_o_valid}, 32'd1);
        chk_eq({tag, " data"}, m_o_data_rd, exp);
        chk_eq({tag, " we"}, {31'd0, m_o_we}, 32'd1);
        chk_eq({tag, " rd"}, {27'd0, m_o_addr_rd}, 32'd7);
    endtask

    initial begin
        m_rst = 1'b1; m_i_valid = 1'b0; m_i_opcode = 11'd0; m_i_funct3 = 3'd0;
        m_i_result_alu = 32'd0; m_i_rs2 = 32'd0; m_i_addr_rd = 5'd0; m_i_we = 1'b0;
        m_i_pc = 32'h0000_1000; m_i_exception = 6'd0; m_i_mem_ack = 1'b0; m_i_mem_rdata = 32'd0;
        tick(); tick();
        chk_eq("rst ready", {31'd0, m_o_ready}, 32'd1);
        chk_eq("rst req", {31'd0, m_o_mem_req}, 32'd0);
        chk_eq("rst valid", {31'd0, m_o_valid}, 32'd0);
        chk_eq("rst data", m_o_data_rd, 32'd0);
        chk_eq("rst exc", {26'd0, m_o_exception}, 32'd0);
        m_rst = 1'b0;
        tick();

        // SW with three request cycles before ack
        issue(OP_STORE, F3_SW, 32'h100, 32'hDEAD_BEEF, 5'd9, 1'b0, 6'h00);
        chk_eq("sw req c1", {31'd0, m_o_mem_req}, 32'd1);
        chk_eq("sw addr", m_o_mem_addr, 32'h100);
        chk_eq("sw wstrb", {28'd0, m_o_mem_wstrb}, 32'hF);
        chk_eq("sw wdata", m_o_mem_wdata, 32'hDEAD_BEEF);
        chk_eq("sw mem_we", {31'd0, m_o_mem_we}, 32'd1);
        chk_eq("sw ready", {31'd0, m_o_ready}, 32'd0);
        tick();
        chk_eq("sw req c2", {31'd0, m_o_mem_req}, 32'd1);
        chk_eq("sw valid c2", {31'd0, m_o_valid}, 32'd0);
        tick();
        chk_eq("sw req c3", {31'd0, m_o_mem_req}, 32'd1);
        chk_eq("sw addr c3", m_o_mem_addr, 32'h100);
        m_i_mem_ack = 1'b1;
        tick();
        m_i_mem_ack = 1'b0;
        chk_eq("sw req done", {31'd0, m_o_mem_req}, 32'd0);
        chk_eq("sw valid", {31'd0, m_o_valid}, 32'd1);
        chk_eq("sw we", {31'd0, m_o_we}, 32'd0);
        chk_eq("sw pc", m_o_pc, 32'h0000_1004);
        chk_eq("sw ready after", {31'd0, m_o_ready}, 32'd1);
        tick();
        chk_eq("sw valid pulse", {31'd0, m_o_valid}, 32'd0);

        // Load lane extraction and extension
        load_zw("lb", F3_LB, 32'h203, 32'h80FF_FF7F, 32'hFFFF_FF80);
        load_zw("lbu", F3_LBU, 32'h203, 32'h80FF_FF7F, 32'h0000_0080);
        load_zw("lhu", F3_LHU, 32'h202, 32'h80FF_FF7F, 32'h0000_80FF);
        load_zw("lh", F3_LH, 32'h202, 32'h80FF_FF7F, 32'hFFFF_80FF);
        load_zw("lb0", F3_LB, 32'h200, 32'h80FF_FF7F, 32'h0000_007F);
        load_zw("lw", F3_LW, 32'h204, 32'h1357_9BDF, 32'h1357_9BDF);

        // Sub-word stores
        issue(OP_STORE, F3_SH, 32'h106, 32'h1234_ABCD, 5'd0, 1'b0, 6'h00);
        chk_eq("sh wstrb", {28'd0, m_o_mem_wstrb}, 32'hC);
        chk_eq("sh wdata", m_o_mem_wdata, 32'hABCD_ABCD);
        chk_eq("sh addr", m_o_mem_addr, 32'h104);
        m_i_mem_ack = 1'b1; tick(); m_i_mem_ack = 1'b0;
        chk_eq("sh valid", {31'd0, m_o_valid}, 32'd1);
        issue(OP_STORE, F3_SB, 32'h101, 32'h1234_ABCD, 5'd0, 1'b0, 6'h00);
        chk_eq("sb wstrb", {28'd0, m_o_mem_wstrb}, 32'h2);
        chk_eq("sb wdata", m_o_mem_wdata, 32'hCDCD_CDCD);
        m_i_mem_ack = 1'b1; tick(); m_i_mem_ack = 1'b0;

        // Faulting accesses never reach memory
        issue(OP_LOAD, F3_LW, 32'h101, 32'h0, 5'd4, 1'b1, 6'h00);
        chk_eq("lw mis req", {31'd0, m_o_mem_req}, 32'd0);
        chk_eq("lw mis valid", {31'd0, m_o_valid}, 32'd1);
        chk_eq("lw mis exc", {26'd0, m_o_exception}, 32'h10);
        chk_eq("lw mis we", {31'd0, m_o_we}, 32'd0);
        chk_eq("lw mis ready", {31'd0, m_o_ready}, 32'd1);
        issue(OP_STORE, F3_SH, 32'h105, 32'h0, 5'd0, 1'b0, 6'h00);
        chk_eq("sh mis req", {31'd0, m_o_mem_req}, 32'd0);
        chk_eq("sh mis exc", {26'd0, m_o_exception}, 32'h20);
        issue(OP_LOAD, 3'b011, 32'h100, 32'h0, 5'd4, 1'b1, 6'h00);
        chk_eq("ld ill req", {31'd0, m_o_mem_req}, 32'd0);
        chk_eq("ld ill exc", {26'd0, m_o_exception}, 32'h01);
        chk_eq("ld ill we", {31'd0, m_o_we}, 32'd0);
        issue(OP_STORE, F3_SW, 32'h100, 32'h0, 5'd0, 1'b0, 6'h00);
        m_i_mem_ack = 1'b1; tick(); m_i_mem_ack = 1'b0;
        issue(OP_STORE, 3'b011, 32'h100, 32'h0, 5'd0, 1'b0, 6'h00);
        chk_eq("st ill req", {31'd0, m_o_mem_req}, 32'd0);
        chk_eq("st ill exc", {26'd0, m_o_exception}, 32'h01);

        // Pass-through ops
        issue(OP_ALU, 3'b000, 32'h5, 32'h0, 5'd3, 1'b1, 6'h00);
        chk_eq("add valid", {31'd0, m_o_valid}, 32'd1);
        chk_eq("add data", m_o_data_rd, 32'h5);
        chk_eq("add we", {31'd0, m_o_we}, 32'd1);
        chk_eq("add rd", {27'd0, m_o_addr_rd}, 32'd3);
        chk_eq("add req", {31'd0, m_o_mem_req}, 32'd0);
        issue(OP_ALU, 3'b000, 32'h5, 32'h0, 5'd0, 1'b1, 6'h00);
        chk_eq("add rd0 we", {31'd0, m_o_we}, 32'd0);
        issue(OP_ALU, 3'b000, 32'h9, 32'h0, 5'd3, 1'b1, 6'h02);
        chk_eq("add exc we", {31'd0, m_o_we}, 32'd0);
        chk_eq("add exc", {26'd0, m_o_exception}, 32'h02);

        // Stray ack while idle
        m_i_mem_ack = 1'b1; tick(); m_i_mem_ack = 1'b0;
        chk_eq("stray ack valid", {31'd0, m_o_valid}, 32'd0);

        // Reset while a request is outstanding
        issue(OP_LOAD, F3_LW, 32'h100, 32'h0, 5'd6, 1'b1, 6'h00);
        chk_eq("rw req", {31'd0, m_o_mem_req}, 32'd1);
        m_rst = 1'b1;
        tick();
        m_rst = 1'b0;
        chk_eq("rw req after rst", {31'd0, m_o_mem_req}, 32'd0);
        chk_eq("rw ready", {31'd0, m_o_ready}, 32'd1);
        chk_eq("rw valid", {31'd0, m_o_valid}, 32'd0);
        m_i_mem_ack = 1'b1; m_i_mem_rdata = 32'h1111_2222;
        tick();
        m_i_mem_ack = 1'b0;
        chk_eq("rw ack valid", {31'd0, m_o_valid}, 32'd0);
        chk_eq("rw ack req", {31'd0, m_o_mem_req}, 32'd0);
        chk_eq("rw ack ready", {31'd0, m_o_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
